// File: rtl/outbound_ipv4_framer.sv
// Outbound IPv4 framer: latches a header, fetches its checksum,
// then emits the 5 header words followed by the UDP segment.
module outbound_ipv4_framer #(
  parameter int CSUM_TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [159:0] hdr_in,
  input  logic         hdr_in_valid,
  output logic         hdr_in_ready,
  output logic [159:0] crc_header,
  output logic         crc_header_valid,
  input  logic [15:0]  crc_checksum,
  input  logic         crc_checksum_valid,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CSUM,
    HDR,
    PAYLOAD
  } state_t;

  localparam logic [8:0] TMO = 9'(CSUM_TIMEOUT);

  state_t       state;
  state_t       state_nxt;
  logic [159:0] hdr_reg;
  logic [2:0]   idx;
  logic [7:0]   cnt;
  logic [8:0]   cnt_inc;
  logic [31:0]  hdr_word;
  logic         hdr_acc;
  logic         csum_take;
  logic         csum_idle;
  logic         cnt_expire;
  logic         hdr_beat;

  assign hdr_acc    = (state == IDLE) && hdr_in_valid;
  assign csum_take  = (state == WAIT_CSUM) && crc_checksum_valid;
  assign csum_idle  = (state == WAIT_CSUM) && !crc_checksum_valid;
  assign cnt_inc    = {1'b0, cnt} + 9'd1;
  assign cnt_expire = csum_idle && (cnt_inc == TMO);
  assign hdr_beat   = (state == HDR) && m_axis_tready;
  assign crc_header = hdr_reg;

  // Select the header word addressed by idx, word 0 first.
  always_comb begin
    hdr_word = hdr_reg[31:0];
    case (idx)
      3'd0:    hdr_word = hdr_reg[159:128];
      3'd1:    hdr_word = hdr_reg[127:96];
      3'd2:    hdr_word = hdr_reg[95:64];
      3'd3:    hdr_word = hdr_reg[63:32];
      default: hdr_word = hdr_reg[31:0];
    endcase
  end

  // Next state and stream outputs; payload is a pure passthrough.
  always_comb begin
    state_nxt     = state;
    hdr_in_ready  = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        hdr_in_ready = 1'b1;
        if (hdr_in_valid)
          state_nxt = WAIT_CSUM;
      end
      WAIT_CSUM: begin
        if (crc_checksum_valid)
          state_nxt = HDR;
        else if (cnt_inc == TMO)
          state_nxt = IDLE;
      end
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_word;
        if (m_axis_tready && idx == 3'd4)
          state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Header store; the checksum lands in bits [79:64] once.
  always_ff @(posedge clk) begin
    if (reset)
      hdr_reg <= '0;
    else if (hdr_acc)
      hdr_reg <= hdr_in;
    else if (csum_take)
      hdr_reg[79:64] <= crc_checksum;
  end

  // Checksum wait counter.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (hdr_acc)
      cnt <= '0;
    else if (csum_idle)
      cnt <= cnt_inc[7:0];
  end

  // Header word index, advanced per accepted beat.
  always_ff @(posedge clk) begin
    if (reset)
      idx <= '0;
    else if (csum_take)
      idx <= '0;
    else if (hdr_beat)
      idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
  end

  // Registered single-cycle launch and timeout pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_header_valid <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      crc_header_valid <= hdr_acc;
      err_timeout      <= cnt_expire;
    end
  end

endmodule

// File: tb/tb_outbound_ipv4_framer.sv
// Randomized bench for outbound_ipv4_framer with a
// packet-level scoreboard and a behavioural checksum unit.
module tb_outbound_ipv4_framer;

  localparam int T = 63;

  logic         clk = 1'b0;
  logic         reset;
  logic [159:0] hdr_in;
  logic         hdr_in_valid;
  logic         hdr_in_ready;
  logic [159:0] crc_header;
  logic         crc_header_valid;
  logic [15:0]  crc_checksum;
  logic         crc_checksum_valid;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         err_timeout;

  outbound_ipv4_framer #(.CSUM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .hdr_in(hdr_in), .hdr_in_valid(hdr_in_valid),
    .hdr_in_ready(hdr_in_ready),
    .crc_header(crc_header),
    .crc_header_valid(crc_header_valid),
    .crc_checksum(crc_checksum),
    .crc_checksum_valid(crc_checksum_valid),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_launch = 0;
  int launch_cyc = 0;
  int n_err = 0;
  int hacc_cyc = 0;
  int rmode = 0;
  int csum_lat = 0;
  bit csum_en = 1;
  bit csum_dup = 0;

  logic [159:0] acc_q[$];
  logic [31:0]  got_data[$];
  logic         got_last[$];
  int           got_cyc[$];
  logic [31:0]  exp_data[$];
  logic         exp_last[$];
  logic [31:0]  pay_data[$];
  logic         pay_last[$];

  localparam logic [159:0] VEC =
    160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;

  // RFC 791 header checksum, checksum field taken as zero.
  function automatic logic [15:0] ip_csum(input logic [159:0] h);
    int unsigned s;
    logic [15:0] w;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      w = 16'(h >> (16 * (9 - i)));
      if (i != 5) s += w;
    end
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    return ~16'(s);
  endfunction

  function automatic logic [159:0] rand_hdr();
    logic [159:0] h;
    h = {$urandom, $urandom, $urandom, $urandom, $urandom};
    h[79:64] = 16'h0;
    return h;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready pattern generator.
  initial begin
    int ph;
    ph = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0)
        m_axis_tready = 1'b1;
      else if (rmode == 1)
        m_axis_tready = (ph % 4 == 0) || (ph % 4 == 3);
      else if (rmode == 2)
        m_axis_tready = 1'($urandom_range(0, 1));
      ph++;
    end
  end

  // Checksum unit: answers csum_lat cycles after launch.
  initial begin
    logic [15:0] c;
    crc_checksum_valid = 1'b0;
    crc_checksum = '0;
    forever begin
      @(posedge clk);
      #1;
      if (crc_header_valid && csum_en && !reset) begin
        c = ip_csum(crc_header);
        for (int k = 0; k < csum_lat; k++) begin
          @(posedge clk);
          #1;
        end
        crc_checksum = c;
        crc_checksum_valid = 1'b1;
        @(posedge clk);
        #1;
        if (csum_dup) begin
          crc_checksum = ~c;
          @(posedge clk);
          #1;
        end
        crc_checksum_valid = 1'b0;
        crc_checksum = '0;
      end
    end
  end

  // Output monitor: launches, errors, stalls and accepted beats.
  initial begin
    logic [159:0] eh;
    logic [31:0]  sdata;
    bit           spend;
    spend = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        spend = 0;
        acc_q.delete();
      end else begin
        if (crc_header_valid) begin
          n_launch++;
          launch_cyc = cyc;
          n_chk++;
          if (acc_q.size() == 0) begin
            n_fail++;
            $display("FAIL launch_hdr: launch with no accepted header");
          end else begin
            eh = acc_q.pop_front();
            if (crc_header !== eh) begin
              n_fail++;
              $display("FAIL launch_hdr: got %h want %h", crc_header, eh);
            end
          end
        end
        if (hdr_in_valid && hdr_in_ready) acc_q.push_back(hdr_in);
        if (err_timeout) n_err++;
        if (spend && m_axis_tvalid) begin
          n_chk++;
          if (m_axis_tdata !== sdata) begin
            n_fail++;
            $display("FAIL stall_hold: got %h want %h", m_axis_tdata, sdata);
          end
        end
        spend = m_axis_tvalid && !m_axis_tready;
        sdata = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
          got_data.push_back(m_axis_tdata);
          got_last.push_back(m_axis_tlast);
          got_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic add_pkt(input logic [159:0] h, input int n);
    logic [15:0] c;
    logic [31:0] w;
    c = ip_csum(h);
    for (int i = 0; i < 5; i++) begin
      w = 32'(h >> (32 * (4 - i)));
      if (i == 2) w[15:0] = c;
      exp_data.push_back(w);
      exp_last.push_back(1'b0);
    end
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_data.push_back(w);
      exp_last.push_back(i == n - 1);
      pay_data.push_back(w);
      pay_last.push_back(i == n - 1);
    end
  endtask

  task automatic accept_hdr(input logic [159:0] h);
    bit acc;
    acc = 0;
    hdr_in = h;
    hdr_in_valid = 1'b1;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      if (hdr_in_ready) begin
        acc = 1;
        hacc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    hdr_in_valid = 1'b0;
    n_chk++;
    if (!acc) begin
      n_fail++;
      $display("FAIL hdr_accept: got 0 want 1");
    end
  endtask

  task automatic drive_beats();
    bit acc;
    while (pay_data.size() > 0) begin
      s_axis_tdata = pay_data.pop_front();
      s_axis_tlast = pay_last.pop_front();
      s_axis_tvalid = 1'b1;
      acc = 0;
      for (int k = 0; k < 1000 && !acc; k++) begin
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        n_chk++;
        n_fail++;
        $display("FAIL pay_accept: got 0 want 1");
        pay_data.delete();
        pay_last.delete();
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_got();
    for (int k = 0; k < 2000 && got_data.size() < exp_data.size(); k++)
      @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_got(input string name);
    int n;
    wait_got();
    n_chk++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d want %0d", name,
               got_data.size(), exp_data.size());
    end
    n = got_data.size() < exp_data.size() ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got %h/%b want %h/%b", name, i,
                 got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    exp_data.delete();
    exp_last.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [159:0] h, input int n,
                             input string name);
    add_pkt(h, n);
    fork
      accept_hdr(h);
      drive_beats();
    join
    check_got(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hdr_in = '0;
    hdr_in_valid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, crc_header_valid,
         err_timeout, hdr_in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000001",
               {m_axis_tvalid, m_axis_tlast, s_axis_tready,
                crc_header_valid, err_timeout, hdr_in_ready});
    end
    n_chk++;
    if (m_axis_tdata !== 32'h0 || crc_header !== 160'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h want 0", m_axis_tdata, crc_header);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] ref_w[5];
    rmode = 0;
    csum_lat = 6;
    csum_dup = 1;
    ref_w = '{32'h45000073, 32'h00004000, 32'h4011b861,
              32'hc0a80001, 32'hc0a800c7};
    add_pkt(VEC, 3);
    fork
      accept_hdr(VEC);
      drive_beats();
    join
    wait_got();
    n_chk++;
    if (got_cyc.size() != 8) begin
      n_fail++;
      $display("FAIL basic_beats: got %0d want 8", got_cyc.size());
    end else begin
      n_chk++;
      if (got_cyc[0] - launch_cyc != 7) begin
        n_fail++;
        $display("FAIL basic_latency: got %0d want 7",
                 got_cyc[0] - launch_cyc);
      end
      for (int i = 1; i < 8; i++) begin
        n_chk++;
        if (got_cyc[i] != got_cyc[i - 1] + 1) begin
          n_fail++;
          $display("FAIL basic_bubble%0d: got %0d want %0d", i,
                   got_cyc[i], got_cyc[i - 1] + 1);
        end
      end
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (got_data[i] !== ref_w[i]) begin
          n_fail++;
          $display("FAIL basic_word%0d: got %h want %h", i,
                   got_data[i], ref_w[i]);
        end
      end
    end
    check_got("basic");
    csum_dup = 0;
  endtask

  task automatic test_stall();
    rmode = 1;
    csum_lat = 3;
    send_packet(VEC, 4, "stall");
    rmode = 0;
  endtask

  task automatic test_timeout();
    int e0;
    int ec;
    bit seen;
    rmode = 0;
    csum_en = 0;
    e0 = n_err;
    seen = 0;
    ec = 0;
    accept_hdr(rand_hdr());
    for (int k = 0; k < T + 20 && !seen; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        seen = 1;
        ec = cyc;
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL timeout_seen: got 0 want 1");
    end else begin
      n_chk++;
      if (ec - launch_cyc != T) begin
        n_fail++;
        $display("FAIL timeout_when: got %0d want %0d", ec - launch_cyc, T);
      end
    end
    @(negedge clk);
    n_chk++;
    if (hdr_in_ready !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: got rdy=%b err=%b want rdy=1 err=0",
               hdr_in_ready, err_timeout);
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if (n_err - e0 != 1 || got_data.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_once: got err=%0d beats=%0d want 1 0",
               n_err - e0, got_data.size());
    end
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    csum_en = 1;
  endtask

  task automatic test_csum_edge();
    int e0;
    rmode = 0;
    csum_lat = T - 1;
    e0 = n_err;
    send_packet(rand_hdr(), 2, "edge");
    n_chk++;
    if (n_err != e0) begin
      n_fail++;
      $display("FAIL edge_err: got %0d want 0", n_err - e0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w2;
    rmode = 3;
    m_axis_tready = 1'b1;
    csum_lat = 2;
    w2 = {VEC[95:80], ip_csum(VEC)};
    accept_hdr(VEC);
    for (int k = 0; k < 100 && got_data.size() < 2; k++)
      @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w2) begin
      n_fail++;
      $display("FAIL rstmid_word2: got %b/%h want 1/%h",
               m_axis_tvalid, m_axis_tdata, w2);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({m_axis_tvalid, m_axis_tlast, hdr_in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_abort: got %b want 001",
               {m_axis_tvalid, m_axis_tlast, hdr_in_ready});
    end
    n_chk++;
    if (got_data.size() != 2 || got_last.sum() != 0) begin
      n_fail++;
      $display("FAIL rstmid_trunc: got %0d beats want 2 without tlast",
               got_data.size());
    end
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    rmode = 0;
    send_packet(VEC, 2, "rstmid_next");
  endtask

  task automatic test_back_to_back();
    logic [159:0] h1;
    logic [159:0] h2;
    int c2;
    int l0;
    int tl;
    rmode = 0;
    csum_lat = 1;
    h1 = rand_hdr();
    h2 = rand_hdr();
    l0 = n_launch;
    c2 = 0;
    add_pkt(h1, 1);
    add_pkt(h2, 1);
    fork
      begin
        accept_hdr(h1);
        accept_hdr(h2);
        c2 = hacc_cyc;
      end
      drive_beats();
    join
    wait_got();
    tl = got_cyc.size() > 5 ? got_cyc[5] : -10;
    n_chk++;
    if (c2 != tl + 1) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d want %0d", c2, tl + 1);
    end
    n_chk++;
    if (n_launch - l0 != 2) begin
      n_fail++;
      $display("FAIL b2b_launch: got %0d want 2", n_launch - l0);
    end
    check_got("b2b");
  endtask

  task automatic test_random();
    rmode = 2;
    for (int p = 0; p < 12; p++) begin
      csum_lat = $urandom_range(0, 8);
      send_packet(rand_hdr(), $urandom_range(1, 6), "rand");
    end
    rmode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_csum_edge();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
